// File: rtl/seq_right_shifter32_pkg.sv
// seq_right_shifter32_pkg
//   Shared constants and types for the ALU32 shifter group.
//   ALU_WIDTH / ALU_SHAMT_W are common with the combinational left shifter,
//   and state_t gives the sequencing states of the multi-cycle right shifter.
package seq_right_shifter32_pkg;

   localparam int ALU_WIDTH   = 32;
   localparam int ALU_SHAMT_W = 5;

   // Code 2'd3 is deliberately unused; the FSM steers it back to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_right_shifter32_rshift_stage.sv
// rshift_stage
//   One combinational barrel stage of the right shifter.
//   Ports:
//     acc    - value entering the stage
//     fill   - bit shifted in from the top (0 logical, sign for arithmetic)
//     enable - when low the stage passes acc through untouched
//     idx    - stage index; the shift distance is 2**idx
//     res    - stage result
module rshift_stage
#(
   parameter int WIDTH = 32,
   parameter int IDX_W = 3
)
(
   input  logic [WIDTH-1:0] acc,
   input  logic             fill,
   input  logic             enable,
   input  logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] res
);

   logic [WIDTH-1:0] amt;
   logic [WIDTH-1:0] fillMask;

   // The fill mask covers exactly the top 2**idx bit positions vacated by
   // the shift, so OR-ing it in gives sign fill without a double-width vector.
   always_comb begin
      amt      = WIDTH'(1) << idx;
      fillMask = fill ? ~({WIDTH{1'b1}} >> amt) : '0;
      res      = enable ? ((acc >> amt) | fillMask) : acc;
   end

endmodule

// File: rtl/seq_right_shifter32.sv
// seq_right_shifter32
//   Multi-cycle 32-bit logical/arithmetic right shifter. One barrel stage
//   (16, 8, 4, 2, 1) is resolved per clock through a single shared
//   rshift_stage, so every operation takes SHAMT_W cycles regardless of
//   the shift amount.
//   Ports:
//     clk, rst            - clock (rising edge), async active-high reset
//     In1, In2, arith     - value, shift amount (low SHAMT_W bits), sign fill
//     in_valid / in_ready - operand handshake, accepted only in IDLE
//     Out, out_valid      - registered result, held until out_ready
//     out_ready           - consumer accepts Out
//     busy                - operation in progress (SHIFT or DONE)
module seq_right_shifter32
   import seq_right_shifter32_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int SHAMT_W = ALU_SHAMT_W
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic             arith,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CNT_W = $clog2(SHAMT_W);

   state_t             state;
   state_t             nextState;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] sh;
   logic               fill;
   logic [WIDTH-1:0]   stageOut;
   logic               unusedIn2;

   // Only the low SHAMT_W bits of In2 select the shift; the rest are ignored.
   assign unusedIn2 = ^In2[WIDTH-1:SHAMT_W];

   // Single shared stage; cnt picks which power-of-two distance applies now.
   rshift_stage #(
      .WIDTH (WIDTH),
      .IDX_W (CNT_W)
   ) u_stage (
      .acc    (acc),
      .fill   (fill),
      .enable (sh[cnt]),
      .idx    (cnt),
      .res    (stageOut)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; the unused encoding falls into the default and
   // recovers to IDLE.
   always_comb begin
      nextState = S_IDLE;
      case (state)
         S_IDLE:  nextState = in_valid ? S_SHIFT : S_IDLE;
         S_SHIFT: nextState = (cnt == '0) ? S_DONE : S_SHIFT;
         S_DONE:  nextState = out_ready ? S_IDLE : S_DONE;
         default: nextState = S_IDLE;
      endcase
   end

   // Handshake outputs decoded straight from state so in_ready is high
   // during and right after reset.
   always_comb begin
      in_ready = (state == S_IDLE);
      busy     = (state != S_IDLE);
   end

   // Datapath: operands and fill are captured once at accept, so later
   // changes on In1/arith cannot disturb the running operation. Out is
   // loaded on the edge that enters DONE with the final stage result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         sh        <= '0;
         fill      <= 1'b0;
         cnt       <= '0;
         Out       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  acc  <= In1;
                  sh   <= In2[SHAMT_W-1:0];
                  fill <= arith & In1[WIDTH-1];
                  cnt  <= CNT_W'(SHAMT_W - 1);
               end
            end
            S_SHIFT: begin
               acc <= stageOut;
               if (cnt == '0) begin
                  Out       <= stageOut;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
